box_muller_sequencer: RTL and testbench

Control block for the Box-Muller Gaussian generator. It fetches 32-bit uniform words from the Tausworthe URNG and splits them into the log/sqrt ROM address (Addr1) and the cos/sin ROM address (Addr2). It times the fixed-latency ROM and multiplier stages and buffers each product pair (x0 = r·cos, x1 = r·sin) into a valid/ready sample stream on grv/outputvalid.

---
 rtl/box_muller_pkg.sv | 24 ++
 rtl/box_muller_sequencer_if.sv | 22 ++
 rtl/bm_out_buffer.sv | 52 +++++
 rtl/box_muller_sequencer.sv | 148 ++++++++++++++
 tb/tb_box_muller_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/box_muller_pkg.sv
// Shared types and defaults for the Box-Muller sequencer: FSM states,
// datapath widths and the default ROM/multiplier latencies.
package box_muller_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int ROM_LAT_DEF = 2;
  localparam int MUL_LAT_DEF = 3;
  localparam int CNT_W       = 3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ROM,
    MUL,
    PUSH
  } bm_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] x0;
    logic [DATA_W-1:0] x1;
  } bm_pair_t;

endpackage

// File: rtl/box_muller_sequencer_if.sv
// Uniform-word request channel and Gaussian sample stream of the sequencer.
interface box_muller_sequencer_if;
  import box_muller_pkg::*;

  logic              urng_req;
  logic              urng_valid;
  logic [31:0]       urng_word;
  logic [DATA_W-1:0] grv;
  logic              outputvalid;
  logic              grv_ready;

  modport master (
    output urng_req, grv, outputvalid,
    input  urng_valid, urng_word, grv_ready
  );

  modport slave (
    input  urng_req, grv, outputvalid,
    output urng_valid, urng_word, grv_ready
  );

endinterface

// File: rtl/bm_out_buffer.sv
// Two-entry sample FIFO: a product pair is written in one cycle, samples
// leave one at a time from the head (x0 first, then x1).
module bm_out_buffer
  import box_muller_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  bm_pair_t          pair_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        count_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem0_q, mem1_q;
  logic [1:0]        count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push_i) begin
      count_d = 2'd2;
    end else if (pop_i && (count_q != 2'd0)) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Payload carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem0_q <= pair_i.x0;
      mem1_q <= pair_i.x1;
    end else if (pop_i) begin
      mem0_q <= mem1_q;
    end
  end

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem0_q;

endmodule

// File: rtl/box_muller_sequencer.sv
// Box-Muller control: fetches uniform words, sequences the fixed-latency ROM
// and multiplier, and queues each product pair onto the sample stream.
module box_muller_sequencer
  import box_muller_pkg::*;
#(
  parameter int ROM_LAT = ROM_LAT_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  box_muller_sequencer_if.master  bus,
  output logic [ADDR_W-1:0]       addr1,
  output logic [ADDR_W-1:0]       addr2,
  output logic                    rom_en,
  output logic                    mul_en,
  input  logic [DATA_W-1:0]       mul_p0,
  input  logic [DATA_W-1:0]       mul_p1,
  output logic                    busy,
  output logic [7:0]              discard_cnt
);

  bm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [7:0]        disc_q, disc_d;
  bm_pair_t          hold_q, hold_d;

  logic              urng_req;
  logic              buf_push, buf_pop, buf_empty, buf_full;
  logic [1:0]        buf_cnt;
  bm_pair_t          buf_pair;
  logic [DATA_W-1:0] buf_head;
  logic              unused_buf_full;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    disc_d   = disc_q;
    hold_d   = hold_q;
    urng_req = 1'b0;
    rom_en   = 1'b0;
    mul_en   = 1'b0;
    buf_push = 1'b0;
    buf_pair = hold_q;

    case (state_q)
      IDLE: begin
        if (enable) state_d = FETCH;
      end
      FETCH: begin
        urng_req = 1'b1;
        if (bus.urng_valid) begin
          // ln(0) is undefined, so a zero u1 is dropped and counted.
          if (bus.urng_word[31:16] == '0) begin
            if (disc_q != 8'hFF) disc_d = disc_q + 8'd1;
          end else begin
            addr1_d = bus.urng_word[31:16];
            addr2_d = bus.urng_word[15:0];
            cnt_d   = '0;
            state_d = ROM;
          end
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
      ROM: begin
        rom_en = (cnt_q == '0);
        if (cnt_q == CNT_W'(ROM_LAT - 1)) begin
          cnt_d   = '0;
          state_d = MUL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MUL: begin
        mul_en = (cnt_q == '0);
        if (cnt_q == CNT_W'(MUL_LAT)) begin
          if (buf_cnt == 2'd0) begin
            buf_push = 1'b1;
            buf_pair = {mul_p0, mul_p1};
            state_d  = enable ? FETCH : IDLE;
          end else begin
            hold_d  = {mul_p0, mul_p1};
            state_d = PUSH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PUSH: begin
        if (buf_empty) begin
          buf_push = 1'b1;
          state_d  = enable ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      disc_q  <= disc_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign buf_pop = !buf_empty && bus.grv_ready;

  bm_out_buffer u_buf (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (buf_push),
    .pair_i  (buf_pair),
    .pop_i   (buf_pop),
    .head_o  (buf_head),
    .count_o (buf_cnt),
    .empty_o (buf_empty),
    .full_o  (buf_full)
  );

  // The FSM never writes unless the buffer is empty, so full is informational.
  assign unused_buf_full = buf_full;

  assign bus.urng_req    = urng_req;
  assign bus.grv         = buf_head;
  assign bus.outputvalid = !buf_empty;
  assign addr1           = addr1_q;
  assign addr2           = addr2_q;
  assign busy            = (state_q != IDLE);
  assign discard_cnt     = disc_q;

endmodule

// File: tb/tb_box_muller_sequencer.sv
// Scoreboard bench: stimulus queues expected samples per accepted word, a
// monitor stubs the ROM/multiplier timing and checks everything leaving the DUT.
module tb_box_muller_sequencer;
  import box_muller_pkg::*;

  localparam int RL = 2;
  localparam int ML = 3;
  localparam logic [DATA_W-1:0] K0 = 16'h5234;
  localparam logic [DATA_W-1:0] K1 = 16'h2BCD;
  localparam logic [DATA_W-1:0] P2_0 = 16'h0F0F;
  localparam logic [DATA_W-1:0] P2_1 = 16'h7E7E;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic [ADDR_W-1:0] addr1, addr2;
  logic rom_en, mul_en, busy;
  logic [DATA_W-1:0] mul_p0, mul_p1;
  logic [7:0] discard_cnt;

  logic en2 = 1'b0;
  logic [ADDR_W-1:0] a1_2, a2_2;
  logic rom_en2, mul_en2, busy2;
  logic [7:0] disc2;

  box_muller_sequencer_if bm ();
  box_muller_sequencer_if bm2 ();

  box_muller_sequencer #(.ROM_LAT(RL), .MUL_LAT(ML)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bm),
    .addr1(addr1), .addr2(addr2), .rom_en(rom_en), .mul_en(mul_en),
    .mul_p0(mul_p0), .mul_p1(mul_p1), .busy(busy), .discard_cnt(discard_cnt)
  );

  box_muller_sequencer #(.ROM_LAT(1), .MUL_LAT(5)) dut2 (
    .clk(clk), .reset(reset), .enable(en2), .bus(bm2),
    .addr1(a1_2), .addr2(a2_2), .rom_en(rom_en2), .mul_en(mul_en2),
    .mul_p0(P2_0), .mul_p1(P2_1), .busy(busy2), .discard_cnt(disc2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] exp_q[$];
  logic [31:0]       acc_q[$];
  int acc_cyc = -100;
  int rom_cyc = -100;
  int prod_cyc = -100;
  logic [DATA_W-1:0] ra1 = '0, ra2 = '0;
  logic rnd_done;
  logic [31:0] w, wa, wb;
  logic [DATA_W-1:0] q2[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: half a cycle away from the active edge.
  always @(negedge clk) begin
    #1;
    if (bm.outputvalid && bm.grv_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_sample actual=%0h required=none", bm.grv);
      end else begin
        check("sample", 64'(bm.grv), 64'(exp_q.pop_front()));
      end
    end
    if (rom_en) begin
      rom_cyc = cyc; ra1 = addr1; ra2 = addr2;
      if (acc_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rom_en_without_word actual=%0h required=none", {addr1, addr2});
      end else begin
        check("addr", 64'({addr1, addr2}), 64'(acc_q.pop_front()));
      end
      check("rom_en_cycle", 64'(cyc - acc_cyc), 64'(1));
    end
    if (mul_en) begin
      check("mul_en_cycle", 64'(cyc - rom_cyc), 64'(RL));
      check("rom_mul_overlap", 64'(rom_en), 64'(0));
      prod_cyc = cyc + ML;
    end
    if (bm2.outputvalid && bm2.grv_ready) q2.push_back(bm2.grv);
    // Products exist only in the cycle the multiplier latency predicts.
    if (cyc == prod_cyc) begin
      mul_p0 = ra1 ^ K0; mul_p1 = ra2 ^ K1;
    end else begin
      mul_p0 = 16'hDEAD; mul_p1 = 16'hBEEF;
    end
  end

  task automatic send_word(input logic [31:0] wd);
    int n = 0;
    bm.urng_valid = 1'b1;
    bm.urng_word  = wd;
    while (!bm.urng_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL urng_accept_timeout actual=none required=%0h", wd);
    end else if (wd[31:16] != 16'h0) begin
      acc_cyc = cyc;
      acc_q.push_back(wd);
      exp_q.push_back(wd[31:16] ^ K0);
      exp_q.push_back(wd[15:0] ^ K1);
    end
    @(negedge clk);
    bm.urng_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bm.outputvalid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", 64'(exp_q.size()), 64'(0));
  endtask

  function automatic logic [31:0] rand_nz();
    logic [31:0] r;
    r = $urandom;
    if (r[31:16] == 16'h0) r[31:16] = 16'h0001;
    return r;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a, reqs, stale, c0, t_mul, t_ov;
    bm.urng_valid = 1'b0; bm.urng_word = '0; bm.grv_ready = 1'b0;
    bm2.urng_valid = 1'b0; bm2.urng_word = '0; bm2.grv_ready = 1'b0;
    rnd_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", 64'({addr1, addr2, rom_en, mul_en, bm.grv, bm.outputvalid,
                             bm.urng_req, busy, discard_cnt}), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // Single pair with the reference products
    bm.grv_ready = 1'b1;
    enable = 1'b1;
    send_word(32'h4000_8000);
    a = acc_cyc;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!bm.outputvalid && n < 40);
    check("first_valid_cycle", 64'(cyc - a), 64'(7));
    check("x0_value", 64'(bm.grv), 64'(16'h1234));
    @(negedge clk); #1;
    check("x1_value", 64'(bm.grv), 64'(16'hABCD));
    check("addr_hold", 64'({addr1, addr2}), 64'(32'h4000_8000));
    @(negedge clk);

    // Zero-u1 rejection and saturation
    send_word(32'h0000_1234);
    #1 check("discard_one", 64'(discard_cnt), 64'(1));
    @(negedge clk);
    send_word(32'h0001_0001);
    drain();
    bm.urng_word = 32'h0000_0055;
    bm.urng_valid = 1'b1;
    repeat (300) @(negedge clk);
    bm.urng_valid = 1'b0;
    #1 check("discard_saturate", 64'(discard_cnt), 64'(255));
    @(negedge clk);

    // Backpressure across two pairs
    bm.grv_ready = 1'b0;
    wa = rand_nz(); wb = rand_nz();
    send_word(wa);
    send_word(wb);
    repeat (12) @(negedge clk);
    #1;
    check("bp_busy_noreq", 64'({busy, bm.urng_req}), 64'(2'b10));
    check("bp_head", 64'(bm.grv), 64'(wa[31:16] ^ K0));
    @(negedge clk);
    bm.grv_ready = 1'b1;
    drain();

    // Enable dropped while the ROM is being read
    send_word(rand_nz());
    enable = 1'b0;
    drain();
    reqs = 0;
    repeat (10) begin @(negedge clk); #1; if (bm.urng_req || busy) reqs++; end
    check("idle_after_drop", 64'(reqs), 64'(0));
    @(negedge clk);

    // Randomized words and consumer stalls
    enable = 1'b1;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          w = $urandom;
          if ($urandom_range(0, 3) == 0) w[31:16] = 16'h0;
          send_word(w);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          bm.grv_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bm.grv_ready = 1'b1;
    drain();

    // Reset in the middle of a pair with a sample buffered
    bm.grv_ready = 1'b0;
    send_word(rand_nz());
    send_word(rand_nz());
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    enable = 1'b0;
    #1;
    check("reset_async", 64'({addr1, addr2, rom_en, mul_en, bm.grv, bm.outputvalid,
                             bm.urng_req, busy, discard_cnt}), 64'(0));
    exp_q.delete();
    acc_q.delete();
    prod_cyc = -100;
    bm.grv_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    stale = 0;
    repeat (10) begin @(negedge clk); #1; if (busy || bm.outputvalid) stale++; end
    check("post_reset_idle", 64'(stale), 64'(0));
    @(negedge clk);
    enable = 1'b1;
    send_word(rand_nz());
    drain();
    enable = 1'b0;

    // Latency parameters ROM_LAT=1, MUL_LAT=5
    bm2.grv_ready = 1'b1;
    bm2.urng_word = 32'h1111_2222;
    bm2.urng_valid = 1'b1;
    en2 = 1'b1;
    n = 0;
    while (!bm2.urng_req && n < 20) begin @(negedge clk); n++; end
    c0 = cyc;
    @(negedge clk);
    bm2.urng_valid = 1'b0;
    en2 = 1'b0;
    #1;
    check("l2_rom_en", 64'(rom_en2), 64'(1));
    check("l2_addr", 64'({a1_2, a2_2}), 64'(32'h1111_2222));
    t_mul = -1; t_ov = -1;
    repeat (20) begin
      @(negedge clk); #1;
      if (mul_en2 && t_mul < 0) t_mul = cyc - c0;
      if (bm2.outputvalid && t_ov < 0) t_ov = cyc - c0;
    end
    check("l2_mul_en_cycle", 64'(t_mul), 64'(2));
    check("l2_first_valid", 64'(t_ov), 64'(8));
    check("l2_count", 64'(q2.size()), 64'(2));
    if (q2.size() == 2) begin
      check("l2_x0", 64'(q2[0]), 64'(P2_0));
      check("l2_x1", 64'(q2[1]), 64'(P2_1));
    end
    check("l2_idle", 64'({busy2, disc2}), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
